pipelined_multiply_accumulate_unit: RTL and testbench
=====================================================

Name: pipelined_multiply_accumulate_unit

Overview:
- Parametrised successor to the single-cycle-pipelined integer multiplier in the PE datapath.
- Configurable word width and pipeline depth, explicit valid tracking, and a persistent internal accumulator for multi-cycle dot products.
- Sits beside the ALU in the PE datapath. Consumes decoded op and up to three operands. Returns a registered result with a valid flag to the writeback mux.

Parameters:
- WORD_WIDTH, TIA_WORD_WIDTH: operand/result width in bits; >= 8.
- PIPELINE_DEPTH, 3: cycles from accepted input to output_valid; >= 1.
- TWO_WORD_PRODUCT, 1: 1 = high-half ops (SHMUL/UHMUL) supported; 0 = they return 0.

Ports:
- clock  input  1  positive-edge clock; the block's only clock.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- enable  input  1  active high; 0 freezes the entire pipeline, including the accumulator and outputs.
- input_valid  input  1  op/operands valid this cycle; sampled only when enable=1.
- op  input  TIA_OP_WIDTH  operation select.
- operand_0  input  WORD_WIDTH  addend for MAC; factor for LMUL/SHMUL/UHMUL/ACC.
- operand_1  input  WORD_WIDTH  factor.
- operand_2  input  WORD_WIDTH  factor for MAC.
- output_valid  output  1  result holds a completed op.
- result  output  WORD_WIDTH  registered result.
- accumulator_busy  output  1  an ACC or ACCRD is in flight (any stage).

Behaviour:
- Reset (async): all stage valid bits, staged ops, staged operands, accumulator, output_valid and result go to 0. In-flight ops are discarded and never produce output.
- Accept: an op enters stage 1 on a rising edge with enable=1 and input_valid=1.
- Bubble: enable=1 with input_valid=0 inserts a bubble (stage valid=0).
- Latency: exactly PIPELINE_DEPTH enabled edges, i.e. output_valid=1 on the cycle after the D-th enabled edge.
- Throughput: one op per enabled cycle; no internal stalls.
- Stall: enable=0 holds every register, including output_valid and result, and ignores inputs.
- Factor select at stage 1:
  - SHMUL: signed op0 x signed op1.
  - LMUL, UHMUL, ACC: unsigned op0 x unsigned op1.
  - MAC: signed op1 x signed op2.
  - Other ops: 0 x 0.
- Product: full 2*WORD_WIDTH bits, carried through stages 2..D-1 (retiming delay). For D=1, the multiply, select and result register all sit in one cycle.
- Result select at the final stage (this becomes the result register):
  - LMUL: low word.
  - SHMUL: signed high word.
  - UHMUL: unsigned high word.
  - MAC: staged op0 + low word, modulo 2^WORD_WIDTH.
  - ACC: accumulator + low word; writes both the accumulator and result.
  - ACCRD: result = accumulator, then accumulator <= 0.
  - Unknown op: result 0 with output_valid=1.
- TWO_WORD_PRODUCT=0: SHMUL/UHMUL give result 0 and the high-half multiplier logic may be pruned.
- Accumulator update happens only at the final stage, so back-to-back ACCs with no gap accumulate correctly. ACC immediately followed by ACCRD returns the sum including that ACC.
- Overflow: all arithmetic wraps; no saturation, no flags.
- Bubble at final stage with enable=1: output_valid <= 0, result holds its previous value, accumulator unchanged.
- Reset during stall or while the pipeline is full: same as normal reset; the first post-reset output appears D cycles after the first accepted op.

Decomposition:
- Datapath package:
  - new opcode constants TIA_OP_ACC and TIA_OP_ACCRD, alongside LMUL/SHMUL/UHMUL/MAC;
  - a typedef for the staged control bundle (valid, op, operand_0).
- Sub-module product_delay_line: parametrised N-stage enable-gated register chain with async reset. Instantiated once for the product and once for the control bundle.

Test Plan (WORD_WIDTH=32, PIPELINE_DEPTH=3):
- Basic ops, enable=1:
  - LMUL 0x0001_0000 x 0x0001_0000 -> output_valid on cycle 3, result 0x0000_0000.
  - UHMUL, same operands -> result 0x0000_0001.
  - SHMUL 0xFFFF_FFFF x 0x0000_0002 -> result 0xFFFF_FFFF.
- MAC op0=10, op1=-3, op2=4 -> result 0xFFFF_FFFE (-2) after 3 cycles.
- Back-to-back accumulate: ACC 2x3, ACC 4x5, ACC 1x1, then ACCRD on consecutive cycles -> results 6, 26, 27, 27. A following ACCRD returns 0.
- Stall mid-flight: issue LMUL 7x6, drop enable for 5 cycles after cycle 1 -> output_valid stays 0 during the stall; result 42 appears 2 enabled cycles after enable returns; outputs frozen while enable=0.
- Async reset mid-operation: 3 ACCs in flight, assert reset between edges -> output_valid and result drop to 0 without a clock edge; the next ACCRD returns 0.
- Bubbles: alternate input_valid 1/0 with LMUL 3x3 -> output_valid toggles 1/0 with matching spacing; result 9 holds during bubbles. Separately, an unknown op -> output_valid=1, result 0.

Source files
------------

// File: rtl/pipelined_multiply_accumulate_unit_pkg.sv
// Shared opcode constants and staged-control types for the PE multiply/accumulate unit.
package pipelined_multiply_accumulate_unit_pkg;

    localparam int TIA_WORD_WIDTH = 32;
    localparam int TIA_OP_WIDTH   = 4;

    typedef logic [TIA_OP_WIDTH-1:0] tia_op_t;

    localparam tia_op_t TIA_OP_NOP   = 4'd0;
    localparam tia_op_t TIA_OP_LMUL  = 4'd1;
    localparam tia_op_t TIA_OP_SHMUL = 4'd2;
    localparam tia_op_t TIA_OP_UHMUL = 4'd3;
    localparam tia_op_t TIA_OP_MAC   = 4'd4;
    localparam tia_op_t TIA_OP_ACC   = 4'd5;
    localparam tia_op_t TIA_OP_ACCRD = 4'd6;

    // Control header of the staged bundle; operand_0 is appended in the top because its width is a module parameter.
    typedef struct packed {
        logic    valid;
        tia_op_t op;
    } stage_ctrl_t;

    function automatic logic is_accumulator_op(input tia_op_t op);
        return (op == TIA_OP_ACC) || (op == TIA_OP_ACCRD);
    endfunction

endpackage

// File: rtl/pipelined_multiply_accumulate_unit_if.sv
// Operand/result bus between the PE decode stage and the multiply/accumulate unit.
interface pipelined_multiply_accumulate_unit_if
    import pipelined_multiply_accumulate_unit_pkg::*;
#(
    parameter int WORD_WIDTH = TIA_WORD_WIDTH
);

    logic                  enable;
    logic                  input_valid;
    tia_op_t               op;
    logic [WORD_WIDTH-1:0] operand_0;
    logic [WORD_WIDTH-1:0] operand_1;
    logic [WORD_WIDTH-1:0] operand_2;
    logic                  output_valid;
    logic [WORD_WIDTH-1:0] result;
    logic                  accumulator_busy;

    modport master (
        output enable, input_valid, op, operand_0, operand_1, operand_2,
        input  output_valid, result, accumulator_busy
    );

    modport slave (
        input  enable, input_valid, op, operand_0, operand_1, operand_2,
        output output_valid, result, accumulator_busy
    );

endinterface

// File: rtl/pipelined_multiply_accumulate_unit_product_delay_line.sv
// Enable-gated register chain with asynchronous clear; used to retime the product and control bundle.
module product_delay_line #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else if (i_enable) begin
            r_stage[0] <= i_data;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[STAGES-1];

endmodule

// File: rtl/pipelined_multiply_accumulate_unit.sv
// Pipelined integer multiplier with MAC and a persistent accumulator; result appears PIPELINE_DEPTH enabled edges after accept.
module pipelined_multiply_accumulate_unit
    import pipelined_multiply_accumulate_unit_pkg::*;
#(
    parameter int WORD_WIDTH       = TIA_WORD_WIDTH,
    parameter int PIPELINE_DEPTH   = 3,
    parameter bit TWO_WORD_PRODUCT = 1'b1
) (
    input logic                               clock,
    input logic                               reset,
    pipelined_multiply_accumulate_unit_if.slave bus
);

    localparam int PRODUCT_WIDTH = 2 * WORD_WIDTH;
    localparam int BUNDLE_WIDTH  = $bits(stage_ctrl_t) + WORD_WIDTH;
    localparam int COUNT_WIDTH   = $clog2(PIPELINE_DEPTH + 1);

    logic [PRODUCT_WIDTH-1:0] w_factor_a;
    logic [PRODUCT_WIDTH-1:0] w_factor_b;
    logic [PRODUCT_WIDTH-1:0] w_product;
    logic [PRODUCT_WIDTH-1:0] w_final_product;
    stage_ctrl_t              w_stage1_ctrl;
    stage_ctrl_t              w_final_ctrl;
    logic [BUNDLE_WIDTH-1:0]  w_stage1_bundle;
    logic [BUNDLE_WIDTH-1:0]  w_final_bundle;
    logic [WORD_WIDTH-1:0]    w_final_operand_0;
    logic [WORD_WIDTH-1:0]    w_accumulate_sum;
    logic [WORD_WIDTH-1:0]    w_result_next;
    logic                     w_acc_issue;
    logic                     w_acc_retire;

    logic                     r_output_valid;
    logic [WORD_WIDTH-1:0]    r_result;
    logic [WORD_WIDTH-1:0]    r_accumulator;
    logic [COUNT_WIDTH-1:0]   r_acc_inflight;

    // Factors are extended to the full product width so one unsigned multiply serves both signed and unsigned ops.
    always_comb begin
        w_factor_a = '0;
        w_factor_b = '0;
        case (bus.op)
            TIA_OP_SHMUL: begin
                if (TWO_WORD_PRODUCT) begin
                    w_factor_a = {{WORD_WIDTH{bus.operand_0[WORD_WIDTH-1]}}, bus.operand_0};
                    w_factor_b = {{WORD_WIDTH{bus.operand_1[WORD_WIDTH-1]}}, bus.operand_1};
                end
            end
            TIA_OP_UHMUL: begin
                if (TWO_WORD_PRODUCT) begin
                    w_factor_a = {{WORD_WIDTH{1'b0}}, bus.operand_0};
                    w_factor_b = {{WORD_WIDTH{1'b0}}, bus.operand_1};
                end
            end
            TIA_OP_LMUL, TIA_OP_ACC: begin
                w_factor_a = {{WORD_WIDTH{1'b0}}, bus.operand_0};
                w_factor_b = {{WORD_WIDTH{1'b0}}, bus.operand_1};
            end
            TIA_OP_MAC: begin
                w_factor_a = {{WORD_WIDTH{bus.operand_1[WORD_WIDTH-1]}}, bus.operand_1};
                w_factor_b = {{WORD_WIDTH{bus.operand_2[WORD_WIDTH-1]}}, bus.operand_2};
            end
            default: ;
        endcase
    end

    assign w_product           = w_factor_a * w_factor_b;
    assign w_stage1_ctrl.valid = bus.input_valid;
    assign w_stage1_ctrl.op    = bus.op;
    assign w_stage1_bundle     = {w_stage1_ctrl, bus.operand_0};
    assign {w_final_ctrl, w_final_operand_0} = w_final_bundle;

    generate
        if (PIPELINE_DEPTH > 1) begin : g_retime
            product_delay_line #(.WIDTH(PRODUCT_WIDTH), .STAGES(PIPELINE_DEPTH - 1)) u_product_delay (
                .clock    (clock),
                .reset    (reset),
                .i_enable (bus.enable),
                .i_data   (w_product),
                .o_data   (w_final_product)
            );
            product_delay_line #(.WIDTH(BUNDLE_WIDTH), .STAGES(PIPELINE_DEPTH - 1)) u_ctrl_delay (
                .clock    (clock),
                .reset    (reset),
                .i_enable (bus.enable),
                .i_data   (w_stage1_bundle),
                .o_data   (w_final_bundle)
            );
        end else begin : g_single_cycle
            assign w_final_product = w_product;
            assign w_final_bundle  = w_stage1_bundle;
        end
    endgenerate

    always_comb begin
        w_accumulate_sum = r_accumulator + w_final_product[WORD_WIDTH-1:0];
        w_result_next    = '0;
        case (w_final_ctrl.op)
            TIA_OP_LMUL:               w_result_next = w_final_product[WORD_WIDTH-1:0];
            TIA_OP_SHMUL, TIA_OP_UHMUL: begin
                if (TWO_WORD_PRODUCT) begin
                    w_result_next = w_final_product[PRODUCT_WIDTH-1:WORD_WIDTH];
                end
            end
            TIA_OP_MAC:                w_result_next = w_final_operand_0 + w_final_product[WORD_WIDTH-1:0];
            TIA_OP_ACC:                w_result_next = w_accumulate_sum;
            TIA_OP_ACCRD:              w_result_next = r_accumulator;
            default: ;
        endcase
    end

    // The accumulator only changes at the final stage, so consecutive ACC/ACCRD ops see each other's effect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_output_valid <= 1'b0;
            r_result       <= '0;
            r_accumulator  <= '0;
        end else if (bus.enable) begin
            r_output_valid <= w_final_ctrl.valid;
            if (w_final_ctrl.valid) begin
                r_result <= w_result_next;
                if (w_final_ctrl.op == TIA_OP_ACC) begin
                    r_accumulator <= w_accumulate_sum;
                end else if (w_final_ctrl.op == TIA_OP_ACCRD) begin
                    r_accumulator <= '0;
                end
            end
        end
    end

    assign w_acc_issue  = bus.input_valid && is_accumulator_op(bus.op);
    assign w_acc_retire = w_final_ctrl.valid && is_accumulator_op(w_final_ctrl.op);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc_inflight <= '0;
        end else if (bus.enable) begin
            r_acc_inflight <= r_acc_inflight + COUNT_WIDTH'(w_acc_issue) - COUNT_WIDTH'(w_acc_retire);
        end
    end

    assign bus.output_valid     = r_output_valid;
    assign bus.result           = r_result;
    assign bus.accumulator_busy = (r_acc_inflight != '0);

endmodule

// File: tb/tb_pipelined_multiply_accumulate_unit.sv
// Directed and randomized bench for the multiply/accumulate unit, checked against a latency-queue reference model.
module tb_pipelined_multiply_accumulate_unit;
    import pipelined_multiply_accumulate_unit_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 3;

    typedef struct {
        bit          valid;
        tia_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } txn_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    pipelined_multiply_accumulate_unit_if #(.WORD_WIDTH(WIDTH)) bus ();

    pipelined_multiply_accumulate_unit #(
        .WORD_WIDTH       (WIDTH),
        .PIPELINE_DEPTH   (DEPTH),
        .TWO_WORD_PRODUCT (1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    txn_t        pending[$];
    logic [31:0] mAcc;
    logic [31:0] mResult;
    bit          mValid;
    bit          mBusy;
    int          vectorCount = 0;
    int          miscompareCount = 0;

    task automatic modelReset();
        pending.delete();
        mAcc    = 32'd0;
        mResult = 32'd0;
        mValid  = 1'b0;
        mBusy   = 1'b0;
    endtask

    // Arithmetic straight from the op definitions, using 64-bit integers.
    task automatic modelRetire(input txn_t t);
        longint unsigned up;
        longint          sp;
        up = 64'(t.a) * 64'(t.b);
        sp = longint'($signed(t.a)) * longint'($signed(t.b));
        case (t.op)
            TIA_OP_LMUL:  mResult = up[31:0];
            TIA_OP_UHMUL: mResult = up[63:32];
            TIA_OP_SHMUL: mResult = sp[63:32];
            TIA_OP_MAC:   mResult = t.a + 32'(longint'($signed(t.b)) * longint'($signed(t.c)));
            TIA_OP_ACC: begin
                mAcc    = mAcc + up[31:0];
                mResult = mAcc;
            end
            TIA_OP_ACCRD: begin
                mResult = mAcc;
                mAcc    = 32'd0;
            end
            default:      mResult = 32'd0;
        endcase
    endtask

    // Each enabled edge admits one entry; the entry DEPTH edges old reaches the output.
    task automatic modelStep(input txn_t t);
        txn_t done;
        pending.push_back(t);
        if (pending.size() == DEPTH) begin
            done   = pending.pop_front();
            mValid = done.valid;
            if (done.valid) modelRetire(done);
        end
        mBusy = 1'b0;
        foreach (pending[i]) begin
            if (pending[i].valid && (pending[i].op == TIA_OP_ACC || pending[i].op == TIA_OP_ACCRD)) mBusy = 1'b1;
        end
    endtask

    task automatic applyStimulus(input bit en, input bit v, input tia_op_t op,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        txn_t t;
        bus.enable      = en;
        bus.input_valid = v;
        bus.op          = op;
        bus.operand_0   = a;
        bus.operand_1   = b;
        bus.operand_2   = c;
        t.valid = v;
        t.op    = op;
        t.a     = a;
        t.b     = b;
        t.c     = c;
        @(posedge clock);
        if (en) modelStep(t);
        #1;
    endtask

    task automatic resetDut();
        bus.enable      = 1'b0;
        bus.input_valid = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        modelReset();
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        vectorCount++;
        if (bus.output_valid !== 1'b0) begin
            miscompareCount++;
            $display("[TB] FAIL reset_valid: got %0b expected 0", bus.output_valid);
        end
        vectorCount++;
        if (bus.result !== 32'h0) begin
            miscompareCount++;
            $display("[TB] FAIL reset_result: got 0x%08h expected 0x00000000", bus.result);
        end
        vectorCount++;
        if (bus.accumulator_busy !== 1'b0) begin
            miscompareCount++;
            $display("[TB] FAIL reset_busy: got %0b expected 0", bus.accumulator_busy);
        end
        #2;
        reset = 1'b0;
        modelReset();
    endtask

    task automatic test_basic_ops();
        tia_op_t     ops[3]  = '{TIA_OP_LMUL, TIA_OP_UHMUL, TIA_OP_SHMUL};
        logic [31:0] opA[3]  = '{32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFFF};
        logic [31:0] opB[3]  = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0002};
        logic [31:0] expR[3] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        bit          expValid;
        logic [31:0] expResult;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) applyStimulus(1'b1, 1'b1, ops[i], opA[i], opB[i], 32'h0);
            else       applyStimulus(1'b1, 1'b0, TIA_OP_NOP, 32'h0, 32'h0, 32'h0);
            expValid  = (i >= 2) && (i <= 4);
            expResult = (i >= 2 && i <= 4) ? expR[i-2] : 32'hFFFF_FFFF;
            vectorCount++;
            if (bus.output_valid !== expValid) begin
                miscompareCount++;
                $display("[TB] FAIL basic_valid[%0d]: got %0b expected %0b", i, bus.output_valid, expValid);
            end
            if (i >= 2) begin
                vectorCount++;
                if (bus.result !== expResult) begin
                    miscompareCount++;
                    $display("[TB] FAIL basic_result[%0d]: got 0x%08h expected 0x%08h", i, bus.result, expResult);
                end
            end
        end
    endtask

    task automatic test_mac();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, i == 0, TIA_OP_MAC, 32'd10, 32'hFFFF_FFFD, 32'd4);
            vectorCount++;
            if (bus.output_valid !== (i == 2)) begin
                miscompareCount++;
                $display("[TB] FAIL mac_valid[%0d]: got %0b expected %0b", i, bus.output_valid, i == 2);
            end
        end
        vectorCount++;
        if (bus.result !== 32'hFFFF_FFFE) begin
            miscompareCount++;
            $display("[TB] FAIL mac_result: got 0x%08h expected 0xfffffffe", bus.result);
        end
    endtask

    task automatic test_back_to_back();
        tia_op_t     ops[5]  = '{TIA_OP_ACC, TIA_OP_ACC, TIA_OP_ACC, TIA_OP_ACCRD, TIA_OP_ACCRD};
        logic [31:0] opA[5]  = '{32'd2, 32'd4, 32'd1, 32'd0, 32'd0};
        logic [31:0] opB[5]  = '{32'd3, 32'd5, 32'd1, 32'd0, 32'd0};
        logic [31:0] expR[5] = '{32'd6, 32'd26, 32'd27, 32'd27, 32'd0};
        for (int i = 0; i < 7; i++) begin
            if (i < 5) applyStimulus(1'b1, 1'b1, ops[i], opA[i], opB[i], 32'h0);
            else       applyStimulus(1'b1, 1'b0, TIA_OP_NOP, 32'h0, 32'h0, 32'h0);
            vectorCount++;
            if (bus.accumulator_busy !== (i <= 5)) begin
                miscompareCount++;
                $display("[TB] FAIL b2b_busy[%0d]: got %0b expected %0b", i, bus.accumulator_busy, i <= 5);
            end
            if (i >= 2) begin
                vectorCount++;
                if ({bus.output_valid, bus.result} !== {1'b1, expR[i-2]}) begin
                    miscompareCount++;
                    $display("[TB] FAIL b2b_result[%0d]: got valid=%0b result=%0d expected valid=1 result=%0d",
                             i, bus.output_valid, bus.result, expR[i-2]);
                end
            end
        end
    endtask

    task automatic test_stall();
        applyStimulus(1'b1, 1'b1, TIA_OP_LMUL, 32'd7, 32'd6, 32'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, TIA_OP_ACC, 32'd100, 32'd100, 32'h0);
            vectorCount++;
            if ({bus.output_valid, bus.result} !== {1'b0, mResult}) begin
                miscompareCount++;
                $display("[TB] FAIL stall_frozen[%0d]: got valid=%0b result=%0d expected valid=0 result=%0d",
                         i, bus.output_valid, bus.result, mResult);
            end
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, TIA_OP_NOP, 32'h0, 32'h0, 32'h0);
            vectorCount++;
            if (bus.output_valid !== (i == 1)) begin
                miscompareCount++;
                $display("[TB] FAIL stall_resume_valid[%0d]: got %0b expected %0b", i, bus.output_valid, i == 1);
            end
        end
        vectorCount++;
        if (bus.result !== 32'd42) begin
            miscompareCount++;
            $display("[TB] FAIL stall_result: got %0d expected 42", bus.result);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, TIA_OP_ACC, 32'd9, 32'd9, 32'h0);
            vectorCount++;
            if ({bus.output_valid, bus.result, bus.accumulator_busy} !== {1'b1, 32'd42, 1'b0}) begin
                miscompareCount++;
                $display("[TB] FAIL stall_hold[%0d]: got valid=%0b result=%0d busy=%0b expected valid=1 result=42 busy=0",
                         i, bus.output_valid, bus.result, bus.accumulator_busy);
            end
        end
        applyStimulus(1'b1, 1'b0, TIA_OP_NOP, 32'h0, 32'h0, 32'h0);
        vectorCount++;
        if ({bus.output_valid, bus.result} !== {1'b0, 32'd42}) begin
            miscompareCount++;
            $display("[TB] FAIL stall_bubble: got valid=%0b result=%0d expected valid=0 result=42",
                     bus.output_valid, bus.result);
        end
    endtask

    task automatic test_async_reset();
        resetDut();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, TIA_OP_ACC, 32'd5, 32'd5, 32'h0);
        vectorCount++;
        if ({bus.output_valid, bus.result} !== {1'b1, 32'd25}) begin
            miscompareCount++;
            $display("[TB] FAIL areset_pre: got valid=%0b result=%0d expected valid=1 result=25",
                     bus.output_valid, bus.result);
        end
        reset = 1'b1;
        #1;
        vectorCount++;
        if ({bus.output_valid, bus.result, bus.accumulator_busy} !== {1'b0, 32'd0, 1'b0}) begin
            miscompareCount++;
            $display("[TB] FAIL areset_clear: got valid=%0b result=%0d busy=%0b expected all 0",
                     bus.output_valid, bus.result, bus.accumulator_busy);
        end
        #2;
        reset = 1'b0;
        modelReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, i == 0, TIA_OP_ACCRD, 32'h0, 32'h0, 32'h0);
            vectorCount++;
            if ({bus.output_valid, bus.result} !== {i == 2, 32'd0}) begin
                miscompareCount++;
                $display("[TB] FAIL areset_accrd[%0d]: got valid=%0b result=%0d expected valid=%0b result=0",
                         i, bus.output_valid, bus.result, i == 2);
            end
        end
    endtask

    task automatic test_bubbles();
        bit v;
        bit expValid;
        for (int k = 1; k <= 10; k++) begin
            v = (k <= 8) && (k % 2 == 1);
            applyStimulus(1'b1, v, TIA_OP_LMUL, 32'd3, 32'd3, 32'h0);
            expValid = (k >= 3) && (k % 2 == 1);
            vectorCount++;
            if (bus.output_valid !== expValid) begin
                miscompareCount++;
                $display("[TB] FAIL bubble_valid[%0d]: got %0b expected %0b", k, bus.output_valid, expValid);
            end
            if (k >= 3) begin
                vectorCount++;
                if (bus.result !== 32'd9) begin
                    miscompareCount++;
                    $display("[TB] FAIL bubble_result[%0d]: got %0d expected 9", k, bus.result);
                end
            end
        end
        applyStimulus(1'b1, 1'b1, 4'hF, $urandom, $urandom, $urandom);
        applyStimulus(1'b1, 1'b0, TIA_OP_NOP, 32'h0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, TIA_OP_NOP, 32'h0, 32'h0, 32'h0);
        vectorCount++;
        if ({bus.output_valid, bus.result} !== {1'b1, 32'd0}) begin
            miscompareCount++;
            $display("[TB] FAIL unknown_op: got valid=%0b result=0x%08h expected valid=1 result=0x00000000",
                     bus.output_valid, bus.result);
        end
    endtask

    task automatic test_random();
        bit      en;
        bit      v;
        tia_op_t op;
        resetDut();
        for (int n = 0; n < 400; n++) begin
            if (n == 200) resetDut();
            en = ($urandom_range(0, 3) != 0);
            v  = ($urandom_range(0, 3) != 0);
            op = TIA_OP_WIDTH'($urandom_range(0, 7));
            applyStimulus(en, v, op, randOperand(), randOperand(), randOperand());
            vectorCount++;
            if (bus.output_valid !== mValid) begin
                miscompareCount++;
                $display("[TB] FAIL random_valid[%0d]: got %0b expected %0b", n, bus.output_valid, mValid);
            end
            vectorCount++;
            if (bus.result !== mResult) begin
                miscompareCount++;
                $display("[TB] FAIL random_result[%0d]: got 0x%08h expected 0x%08h", n, bus.result, mResult);
            end
            vectorCount++;
            if (bus.accumulator_busy !== mBusy) begin
                miscompareCount++;
                $display("[TB] FAIL random_busy[%0d]: got %0b expected %0b", n, bus.accumulator_busy, mBusy);
            end
        end
    endtask

    initial begin
        bus.enable      = 1'b0;
        bus.input_valid = 1'b0;
        bus.op          = TIA_OP_NOP;
        bus.operand_0   = 32'h0;
        bus.operand_1   = 32'h0;
        bus.operand_2   = 32'h0;
        modelReset();
        test_reset();
        test_basic_ops();
        test_mac();
        test_back_to_back();
        test_stall();
        test_async_reset();
        test_bubbles();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
